// File: rtl/m_a_pkg.sv
// Shared definitions for the bit-serial m_a sequencer: FSM encoding and the
// truth tables of the three-input m_a cell (bit n of a table = output for
// index n, where index = {x1, x2, x3}).
package m_a_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [7:0] Z1_TT = 8'b10110110;
  localparam logic [7:0] Z2_TT = 8'b11101000;

endpackage : m_a_pkg

// File: rtl/m_a.sv
// Combinational three-input cell m_a. z1 and z2 are table lookups indexed by
// {x1, x2, x3}; z2 is the majority function.
module m_a
  import m_a_pkg::*;
(
  input  logic x1_i,
  input  logic x2_i,
  input  logic x3_i,
  output logic z1_o,
  output logic z2_o
);

  logic [2:0] idx;

  assign idx  = {x1_i, x2_i, x3_i};
  assign z1_o = Z1_TT[idx];
  assign z2_o = Z2_TT[idx];

endmodule : m_a

// File: rtl/m_a_seq.sv
// Bit-serial sequencer around one m_a cell. Operands are streamed LSB-first,
// z2 is fed back as the x3 state bit and z1 is shifted into the result word.
//
// Handshake: start is a request sampled only in IDLE or DONE; when sampled
// high there the operands are captured on that edge. start in RUN is ignored
// (no queueing). done is a one-cycle pulse; result/cout hold until the next
// accepted start. dbg_state mirrors the FSM state register.
module m_a_seq
  import m_a_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic [1:0]       dbg_state
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             s_q, s_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             z1, z2;
  logic             accept;
  logic [WIDTH:0]   res_shift;

  m_a u_cell (
    .x1_i (a_sh_q[0]),
    .x2_i (b_sh_q[0]),
    .x3_i (s_q),
    .z1_o (z1),
    .z2_o (z2)
  );

  assign accept    = start && ((state_q == IDLE) || (state_q == DONE));
  // New z1 enters at the MSB; slicing the widened word also works for WIDTH=1.
  assign res_shift = {z1, result_q};

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs, decoded from the state register only
  always_comb begin
    busy      = (state_q == RUN);
    done      = (state_q == DONE);
    dbg_state = state_q;
  end

  // Datapath next-state: load on accept, shift one bit per RUN cycle
  always_comb begin
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    s_d      = s_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    cout_d   = cout_q;
    if (accept) begin
      a_sh_d   = a;
      b_sh_d   = b;
      s_d      = cin;
      cnt_d    = '0;
      result_d = '0;
      cout_d   = 1'b0;
    end else if (state_q == RUN) begin
      a_sh_d   = a_sh_q >> 1;
      b_sh_d   = b_sh_q >> 1;
      s_d      = z2;
      cnt_d    = cnt_q + CW'(1);
      result_d = res_shift[WIDTH:1];
      if (cnt_q == LAST) cout_d = z2;
    end
  end

  // Datapath registers; reset discards any partial result
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      s_q      <= 1'b0;
      cnt_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      s_q      <= s_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign result = result_q;
  assign cout   = cout_q;

endmodule : m_a_seq

// File: tb/tb_m_a_seq.sv
// Directed and random bench for m_a_seq: a WIDTH=4 instance for the directed
// timing/function vectors and a WIDTH=8 instance for random operations
// checked against a bit-serial model of the m_a truth tables.
module tb_m_a_seq;
  import m_a_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // WIDTH=4 instance
  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] result4;
  logic [1:0] state4;

  // WIDTH=8 instance
  logic       start8, cin8;
  logic [7:0] a8, b8;
  logic       busy8, done8, cout8;
  logic [7:0] result8;
  logic [1:0] state8;

  m_a_seq #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4),
    .dbg_state(state4)
  );

  m_a_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8),
    .dbg_state(state8)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  logic [8:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Issue one op on the WIDTH=4 instance and wait for done (bounded).
  // lat = cycles from the accept edge to done visible; busy_n = busy cycles.
  task automatic op4(input logic [3:0] a, input logic [3:0] b, input logic c,
                     input bit hold, output int lat, output int busy_n);
    a4 = a; b4 = b; cin4 = c; start4 = 1'b1;
    tick();
    if (!hold) start4 = 1'b0;
    lat = 0;
    busy_n = 0;
    while (!done4 && lat < 20) begin
      if (busy4) busy_n++;
      tick();
      lat++;
    end
    start4 = 1'b0;
  endtask

  // Bit-serial reference built from the cell truth tables.
  function automatic logic [8:0] model8(input logic [7:0] a, input logic [7:0] b, input logic c);
    logic [7:0] z1t, z2t, r;
    logic [2:0] idx;
    logic       s;
    z1t = Z1_TT;
    z2t = Z2_TT;
    s = c;
    r = '0;
    for (int i = 0; i < 8; i++) begin
      idx  = {a[i], b[i], s};
      r[i] = z1t[idx];
      s    = z2t[idx];
    end
    return {s, r};
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_n, c0, k;
    logic [8:0] exp;

    rst = 1'b1;
    start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0;
    tick();
    tick();
    rst = 1'b0;

    // Reset state
    check("rst_busy",   busy4,   0);
    check("rst_done",   done4,   0);
    check("rst_result", result4, 0);
    check("rst_cout",   cout4,   0);
    check("rst_state",  state4,  IDLE);
    check("rst_state8", state8,  IDLE);

    // Vector 1: 0011 / 0101 / 0 -> 1010, cout 0, latency 4
    op4(4'b0011, 4'b0101, 1'b0, 1'b0, lat, busy_n);
    check("v1_latency", lat,     4);
    check("v1_busy_n",  busy_n,  4);
    check("v1_result",  result4, 4'b1010);
    check("v1_cout",    cout4,   0);
    check("v1_state",   state4,  DONE);
    tick();
    check("v1_done_pulse", done4,  0);
    check("v1_idle",       state4, IDLE);
    check("v1_hold",       result4, 4'b1010);

    // Vector 2: 0 / 0 / 1 -> 0001, cout 0
    op4(4'h0, 4'h0, 1'b1, 1'b0, lat, busy_n);
    check("v2_result", result4, 4'b0001);
    check("v2_cout",   cout4,   0);
    tick();

    // Vector 3: F / F / 1 -> F, cout 1
    op4(4'hF, 4'hF, 1'b1, 1'b0, lat, busy_n);
    check("v3_result", result4, 4'hF);
    check("v3_cout",   cout4,   1);
    tick();

    // start held high through RUN: single op, busy exactly 4 cycles
    op4(4'hF, 4'h0, 1'b0, 1'b1, lat, busy_n);
    check("hold_busy_n", busy_n,  4);
    check("hold_result", result4, 4'hF);
    check("hold_cout",   cout4,   0);
    tick();
    check("hold_idle",   state4,  IDLE);
    check("hold_busy",   busy4,   0);

    // Back-to-back: restart in the done cycle, second done 5 cycles later
    op4(4'hF, 4'hF, 1'b1, 1'b0, lat, busy_n);
    c0 = cyc;
    op4(4'b0011, 4'b0101, 1'b0, 1'b0, lat, busy_n);
    check("b2b_gap",    cyc - c0, 5);
    check("b2b_done",   done4,    1);
    check("b2b_result", result4,  4'b1010);
    check("b2b_cout",   cout4,    0);
    tick();

    // Reset during bit 2 of a run aborts and clears outputs
    a4 = 4'hF; b4 = 4'hF; cin4 = 1'b1; start4 = 1'b1;
    tick();
    start4 = 1'b0;
    tick();
    tick();
    check("mid_busy_before", busy4, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy",   busy4,   0);
    check("mid_result", result4, 0);
    check("mid_cout",   cout4,   0);
    check("mid_state",  state4,  IDLE);
    op4(4'b0011, 4'b0101, 1'b0, 1'b0, lat, busy_n);
    check("mid_after_latency", lat,     4);
    check("mid_after_result",  result4, 4'b1010);
    tick();

    // Reset and start in the same cycle: reset wins
    rst = 1'b1; start4 = 1'b1; a4 = 4'h5; b4 = 4'hA; cin4 = 1'b1;
    tick();
    rst = 1'b0; start4 = 1'b0;
    check("rst_wins_state", state4, IDLE);
    check("rst_wins_busy",  busy4,  0);
    tick();
    check("rst_wins_state2", state4, IDLE);

    // Random ops on the WIDTH=8 instance, issued back-to-back
    for (int n = 0; n < 1000; n++) begin
      a8   = 8'($urandom_range(0, 255));
      b8   = 8'($urandom_range(0, 255));
      cin8 = 1'($urandom_range(0, 1));
      exp_q.push_back(model8(a8, b8, cin8));
      start8 = 1'b1;
      tick();
      start8 = 1'b0;
      k = 0;
      while (!done8 && k < 30) begin
        tick();
        k++;
      end
      if (!done8) begin
        check("rand_timeout", 0, 1);
      end else begin
        exp = exp_q.pop_front();
        check("rand_latency", k, 8);
        check("rand_result", {cout8, result8}, exp);
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_m_a_seq
